// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared constants for the GPIO port: register indices of the word-addressed
// register map, the peripheral bus data width and the startup settle count
// used before edge events are allowed to set pending bits.
// -----------------------------------------------------------------------------
package gpio_pkg;

    localparam int GPIO_BUS_W  = 32;
    localparam int GPIO_ADDR_W = 3;

    // Edges seen before the synchroniser has flushed its reset contents are
    // not real pin activity; the counter must reach this value first.
    localparam logic [1:0] GPIO_STARTUP_CNT = 2'd3;

    typedef enum logic [GPIO_ADDR_W-1:0] {
        GPIO_REG_DATA_IN  = 3'd0,
        GPIO_REG_DATA_OUT = 3'd1,
        GPIO_REG_DIR      = 3'd2,
        GPIO_REG_MASK     = 3'd3,
        GPIO_REG_RISE     = 3'd4,
        GPIO_REG_FALL     = 3'd5,
        GPIO_REG_PEND     = 3'd6,
        GPIO_REG_RSVD     = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/gpio_edge_detect.sv
// -----------------------------------------------------------------------------
// gpio_edge_detect
// Two-flop input synchroniser plus a one-flop history stage per pin, and the
// per-pin rising/falling edge qualifiers. Edge outputs are suppressed until a
// short startup count has elapsed after reset.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   pad      in   raw (asynchronous) pin levels
//   rise_en  in   per-pin rising-edge enable
//   fall_en  in   per-pin falling-edge enable
//   sync2    out  synchronised pin levels
//   rise     out  per-pin qualified rising-edge event
//   fall     out  per-pin qualified falling-edge event
// -----------------------------------------------------------------------------
module gpio_edge_detect
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic [WIDTH-1:0] sync2,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] prev;
    logic [1:0]       startup_cnt;
    logic             armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            startup_cnt <= '0;
        end else begin
            // stage 1: first metastability flop
            sync1 <= pad;
            // stage 2: settled level, visible as DATA_IN
            sync2 <= sync1;
            // stage 3: history for edge comparison
            prev  <= sync2;
            if (startup_cnt != GPIO_STARTUP_CNT) begin
                startup_cnt <= startup_cnt + 2'd1;
            end
        end
    end

    // By the time the count saturates, prev already holds a real pin level,
    // so pins that were high through reset cannot look like a rising edge.
    assign armed = (startup_cnt == GPIO_STARTUP_CNT);

    assign rise = sync2 & ~prev & rise_en & {WIDTH{armed}};
    assign fall = ~sync2 & prev & fall_en & {WIDTH{armed}};

endmodule

// File: rtl/gpio_port.sv
// -----------------------------------------------------------------------------
// gpio_port
// Bus-mapped block of WIDTH bidirectional pins. Per-pin direction, output
// value, edge enables, interrupt mask and write-1-to-clear pending bits; one
// level interrupt output formed from pending & mask.
//
// Ports:
//   clk           in    system clock
//   rst_n         in    synchronous active-low reset
//   gpio_address  in    word register index (0..7)
//   gpio_data_i   in    write data
//   gpio_wr       in    1 = write, 0 = read
//   gpio_enable   in    access request
//   gpio_data_o   out   read data, non-zero only while gpio_ready = 1
//   gpio_ready    out   one-cycle access acknowledge
//   gpio_irq      out   level interrupt, OR of (PEND & MASK)
//   gpio_pad      inout pins; driven from DATA_OUT where DIR = 1
// -----------------------------------------------------------------------------
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_ADDR_W-1:0] gpio_address,
    input  logic [GPIO_BUS_W-1:0] gpio_data_i,
    input  logic                  gpio_wr,
    input  logic                  gpio_enable,
    output logic [GPIO_BUS_W-1:0] gpio_data_o,
    output logic                  gpio_ready,
    output logic                  gpio_irq,
    inout  wire  [WIDTH-1:0]      gpio_pad
);

    localparam logic [GPIO_BUS_W-1:0] PIN_MASK = GPIO_BUS_W'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0]      data_out;
    logic [WIDTH-1:0]      dir;
    logic [WIDTH-1:0]      mask;
    logic [WIDTH-1:0]      rise_en;
    logic [WIDTH-1:0]      fall_en;
    logic [WIDTH-1:0]      pend;
    logic [WIDTH-1:0]      data_in;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      fall;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH-1:0]      clr;
    logic [GPIO_BUS_W-1:0] rdata;
    logic [GPIO_BUS_W-1:0] data_i_unused;
    logic                  access;
    logic                  wr_access;

    // Accesses are accepted only while not acknowledging, which caps a master
    // that holds gpio_enable at one access every two cycles.
    assign access    = gpio_enable & ~gpio_ready;
    assign wr_access = access & gpio_wr;
    assign wdata     = gpio_data_i[WIDTH-1:0];
    assign clr       = (wr_access && (gpio_address == GPIO_REG_PEND)) ? wdata : '0;

    // Write bits above WIDTH have no storage behind them.
    assign data_i_unused = gpio_data_i & ~PIN_MASK;

    gpio_edge_detect #(
        .WIDTH (WIDTH)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pad     (gpio_pad),
        .rise_en (rise_en),
        .fall_en (fall_en),
        .sync2   (data_in),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        rdata = '0;
        case (gpio_reg_e'(gpio_address))
            GPIO_REG_DATA_IN:  rdata[WIDTH-1:0] = data_in;
            GPIO_REG_DATA_OUT: rdata[WIDTH-1:0] = data_out;
            GPIO_REG_DIR:      rdata[WIDTH-1:0] = dir;
            GPIO_REG_MASK:     rdata[WIDTH-1:0] = mask;
            GPIO_REG_RISE:     rdata[WIDTH-1:0] = rise_en;
            GPIO_REG_FALL:     rdata[WIDTH-1:0] = fall_en;
            GPIO_REG_PEND:     rdata[WIDTH-1:0] = pend;
            default:           rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out    <= '0;
            dir         <= '0;
            mask        <= '0;
            rise_en     <= '0;
            fall_en     <= '0;
            pend        <= '0;
            gpio_ready  <= 1'b0;
            gpio_data_o <= '0;
        end else begin
            // bus response stage: ack and read data for the access just taken
            gpio_ready  <= access;
            gpio_data_o <= (access && !gpio_wr) ? rdata : '0;

            if (wr_access) begin
                case (gpio_reg_e'(gpio_address))
                    GPIO_REG_DATA_OUT: data_out <= wdata;
                    GPIO_REG_DIR:      dir      <= wdata;
                    GPIO_REG_MASK:     mask     <= wdata;
                    GPIO_REG_RISE:     rise_en  <= wdata;
                    GPIO_REG_FALL:     fall_en  <= wdata;
                    default:           ;
                endcase
            end

            // A new event wins over a clear of the same bit in the same cycle,
            // so an edge arriving during software's clear is never lost.
            pend <= (pend & ~clr) | rise | fall;
        end
    end

    assign gpio_irq = |(pend & mask);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_pad[i] = dir[i] ? data_out[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;

    localparam int W = 8;

    logic        clk;
    logic        rst_n;
    logic [2:0]  gpio_address;
    logic [31:0] gpio_data_i;
    logic        gpio_wr;
    logic        gpio_enable;
    logic [31:0] gpio_data_o;
    logic        gpio_ready;
    logic        gpio_irq;
    wire  [W-1:0] gpio_pad;

    // External pin drivers standing in for board pulls / peripherals.
    logic [W-1:0] ext_en;
    logic [W-1:0] ext_val;

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign gpio_pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    gpio_port #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gpio_address (gpio_address),
        .gpio_data_i  (gpio_data_i),
        .gpio_wr      (gpio_wr),
        .gpio_enable  (gpio_enable),
        .gpio_data_o  (gpio_data_o),
        .gpio_ready   (gpio_ready),
        .gpio_irq     (gpio_irq),
        .gpio_pad     (gpio_pad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit          exp_rd_q[$];
    logic [31:0] exp_val_q[$];
    string       exp_tag_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every ack pops the oldest issued access.
    always @(negedge clk) begin
        if (gpio_ready) begin
            if (exp_rd_q.size() == 0) begin
                chk("spurious_ready", 32'd1, 32'd0);
            end else begin
                bit          is_rd;
                logic [31:0] ev;
                string       tg;
                is_rd = exp_rd_q.pop_front();
                ev    = exp_val_q.pop_front();
                tg    = exp_tag_q.pop_front();
                if (is_rd) chk(tg, gpio_data_o, ev);
            end
        end
    end

    // Caller is at a negedge; drives the request for the next rising edge.
    task automatic bus_start(input logic [2:0] a, input logic w, input logic [31:0] d,
                             input logic [31:0] exp_rd);
        gpio_enable  = 1'b1;
        gpio_wr      = w;
        gpio_address = a;
        gpio_data_i  = d;
        exp_rd_q.push_back(!w);
        exp_val_q.push_back(exp_rd);
        exp_tag_q.push_back($sformatf("rd_reg%0d", a));
    endtask

    task automatic bus_end();
        @(negedge clk);
        chk("ack", 32'(gpio_ready), 32'd1);
        gpio_enable = 1'b0;
        gpio_wr     = 1'b0;
    endtask

    task automatic bus_gap();
        @(negedge clk);
        chk("ack_once", 32'(gpio_ready), 32'd0);
        chk("dout_idle", gpio_data_o, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_start(a, 1'b1, d, 32'd0);
        bus_end();
        bus_gap();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        bus_start(a, 1'b0, 32'd0, e);
        bus_end();
        bus_gap();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        gpio_enable  = 1'b0;
        gpio_wr      = 1'b0;
        gpio_address = 3'd0;
        gpio_data_i  = 32'd0;
        ext_en       = 8'hFF;
        ext_val      = 8'hFF;

        // ---- reset with pins pulled high ----
        idle(3);
        chk("rst_ready", 32'(gpio_ready), 32'd0);
        chk("rst_dout", gpio_data_o, 32'd0);
        chk("rst_irq", 32'(gpio_irq), 32'd0);
        rst_n = 1'b1;
        idle(3);
        rd(3'd0, 32'h0000_00FF);
        rd(3'd6, 32'h0000_0000);
        chk("irq_after_rst", 32'(gpio_irq), 32'd0);
        rd(3'd2, 32'h0000_0000);
        // Undriven pins follow the outside world.
        ext_val = 8'h00;
        idle(3);
        rd(3'd0, 32'h0000_0000);

        // ---- output drive on lower nibble ----
        ext_en  = 8'hF0;
        ext_val = 8'hC0;
        wr(3'd2, 32'h0000_000F);
        wr(3'd1, 32'h0000_00A5);
        chk("pad_lo", 32'(gpio_pad[3:0]), 32'h5);
        chk("pad_hi", 32'(gpio_pad[7:4]), 32'hC);
        idle(1);
        rd(3'd0, 32'h0000_00C5);
        rd(3'd1, 32'h0000_00A5);
        rd(3'd2, 32'h0000_000F);
        wr(3'd2, 32'h0000_0000);
        ext_en  = 8'hFF;
        ext_val = 8'h00;
        idle(3);

        // ---- rising edge on pin0, latency, mask, W1C ----
        wr(3'd4, 32'h0000_0001);
        wr(3'd3, 32'h0000_0001);
        ext_val[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("irq_k1", 32'(gpio_irq), 32'd0);
        @(negedge clk);
        chk("irq_k2", 32'(gpio_irq), 32'd1);
        rd(3'd6, 32'h0000_0001);
        wr(3'd3, 32'h0000_0000);
        chk("irq_masked", 32'(gpio_irq), 32'd0);
        rd(3'd6, 32'h0000_0001);
        wr(3'd3, 32'h0000_0001);
        chk("irq_unmasked", 32'(gpio_irq), 32'd1);
        wr(3'd6, 32'h0000_0001);
        chk("irq_cleared", 32'(gpio_irq), 32'd0);
        rd(3'd6, 32'h0000_0000);

        // ---- both edges on pin1, 4-cycle pulse ----
        wr(3'd4, 32'h0000_0002);
        wr(3'd5, 32'h0000_0002);
        wr(3'd3, 32'h0000_0002);
        ext_val[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("irq_rise1", 32'(gpio_irq), 32'd1);
        bus_start(3'd6, 1'b1, 32'h0000_0002, 32'd0);
        bus_end();
        chk("irq_clr1", 32'(gpio_irq), 32'd0);
        ext_val[1] = 1'b0;
        bus_gap();
        @(negedge clk);
        chk("irq_fall_early", 32'(gpio_irq), 32'd0);
        @(negedge clk);
        chk("irq_fall", 32'(gpio_irq), 32'd1);
        rd(3'd6, 32'h0000_0002);
        wr(3'd6, 32'h0000_0002);
        rd(3'd6, 32'h0000_0000);

        // ---- set beats W1C in the same cycle ----
        wr(3'd4, 32'h0000_0001);
        wr(3'd3, 32'h0000_0001);
        ext_val[0] = 1'b0;
        idle(4);
        rd(3'd6, 32'h0000_0000);
        ext_val[0] = 1'b1;
        idle(4);
        rd(3'd6, 32'h0000_0001);
        ext_val[0] = 1'b0;
        idle(4);
        ext_val[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_start(3'd6, 1'b1, 32'h0000_0001, 32'd0);
        bus_end();
        bus_gap();
        chk("irq_set_wins", 32'(gpio_irq), 32'd1);
        rd(3'd6, 32'h0000_0001);
        wr(3'd6, 32'h0000_0001);
        rd(3'd6, 32'h0000_0000);

        // ---- ignored writes, width clipping, back-to-back reads ----
        wr(3'd0, 32'h0000_0055);
        wr(3'd7, 32'hFFFF_FFFF);
        wr(3'd3, 32'hFFFF_FFFF);
        chk("irq_none_pending", 32'(gpio_irq), 32'd0);
        begin
            logic [31:0] exp_regs [8];
            exp_regs[0] = 32'h0000_0001;
            exp_regs[1] = 32'h0000_00A5;
            exp_regs[2] = 32'h0000_0000;
            exp_regs[3] = 32'h0000_00FF;
            exp_regs[4] = 32'h0000_0001;
            exp_regs[5] = 32'h0000_0002;
            exp_regs[6] = 32'h0000_0000;
            exp_regs[7] = 32'h0000_0000;
            for (int r = 0; r < 8; r++) begin
                bus_start(3'(r), 1'b0, 32'd0, exp_regs[r]);
                @(negedge clk);
                chk("held_ack", 32'(gpio_ready), 32'd1);
                @(negedge clk);
                chk("held_gap", 32'(gpio_ready), 32'd0);
            end
            gpio_enable = 1'b0;
        end
        idle(1);

        // ---- reset during an access ----
        gpio_enable  = 1'b1;
        gpio_wr      = 1'b1;
        gpio_address = 3'd1;
        gpio_data_i  = 32'h0000_003C;
        rst_n        = 1'b0;
        @(negedge clk);
        chk("rst_abort_ready", 32'(gpio_ready), 32'd0);
        chk("rst_abort_dout", gpio_data_o, 32'd0);
        gpio_enable = 1'b0;
        gpio_wr     = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        rd(3'd1, 32'h0000_0000);
        rd(3'd3, 32'h0000_0000);

        chk("sb_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Parametrised GPIO port. It replaces the single tri-state pad cell with a bus-mapped block of WIDTH bidirectional pins.
- Each pin has a per-pin direction register, a registered output value, and a two-flop input synchroniser.
- Edge detection on each pin is selectable as rising, falling or both. Each pin has a maskable, write-1-to-clear interrupt pending bit.
- Sits on the peripheral bus next to the other slaves. Drives one level interrupt line to the interrupt controller.

Parameters:
- WIDTH, 8, number of pins (1..32).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- gpio_address  input  3  word register index.
- gpio_data_i  input  32  write data.
- gpio_wr  input  1  1 = write, 0 = read (qualified by gpio_enable).
- gpio_enable  input  1  access request.
- gpio_data_o  output  32  read data, valid while gpio_ready = 1.
- gpio_ready  output  1  one-cycle access acknowledge.
- gpio_irq  output  1  level interrupt: OR of (PEND & MASK).
- gpio_pad  inout  WIDTH  pins.

Behaviour:
- Reset: clocked on clk, sampled only at rising edges with rst_n = 0. While reset is applied:
  - DATA_OUT, DIR, MASK, RISE, FALL and PEND = 0; all pins are inputs (pad = z).
  - sync1, sync2 and prev = 0; armed = 0 and startup counter = 0.
  - gpio_ready = 0, gpio_data_o = 0, gpio_irq = 0.
  - Reset asserted mid-access aborts the access: no ready pulse and no register write.
- Register map (bits [WIDTH-1:0] only; upper bits read 0 and ignore writes):
  - 0 DATA_IN: read-only, = sync2.
  - 1 DATA_OUT: read/write.
  - 2 DIR: read/write; 1 = pin drives DATA_OUT.
  - 3 MASK: read/write.
  - 4 RISE: read/write, rising-edge enable.
  - 5 FALL: read/write, falling-edge enable.
  - 6 PEND: read; writing 1 clears that bit.
  - 7 reserved: reads 0, writes ignored.
- Pad: gpio_pad[i] = DIR[i] ? DATA_OUT[i] : z. DATA_IN also reflects driven pins, with synchroniser latency.
- Bus handshake:
  - An access is performed at an edge where gpio_enable = 1 and gpio_ready = 0. A write updates the register at that edge.
  - gpio_ready = 1 for exactly the following cycle; gpio_data_o holds the read data during that cycle and is 0 otherwise.
  - The master drops gpio_enable in the ready cycle. If it is held, a new access starts at the next edge, giving a maximum throughput of one access per 2 cycles.
- Synchroniser: sync1 <= pad, sync2 <= sync1, prev <= sync2 on every edge.
- Latency: a pad change before edge k is captured in sync1 at k, shows in sync2/DATA_IN at k+1, and sets PEND at k+2. gpio_irq rises in the cycle after k+2.
- Edge events:
  - rise = sync2 & ~prev & RISE; fall = ~sync2 & prev & FALL.
  - PEND <= (PEND & ~clr) | ((rise | fall) & {WIDTH{armed}}).
  - Set has priority over a W1C clear of the same bit in the same cycle.
  - Bits with both RISE and FALL set flag both edges.
- Startup:
  - A 2-bit counter increments after reset; armed = 1 once it reaches 3, then it saturates.
  - No edge is recorded before armed, so pins that are high at reset do not produce spurious rising events.
- gpio_irq is combinational from the registered PEND and MASK. Masking a pending bit drops gpio_irq but leaves PEND set.
- Changing DIR or the edge-enable registers never clears PEND.

Decomposition:
- Package gpio_pkg:
  - register index constants GPIO_REG_DATA_IN..GPIO_REG_PEND.
  - bus data width constant 32.
  - startup count constant 3.
- One natural sub-module: gpio_edge_detect. Parametrised by WIDTH, it holds sync1, sync2, prev, the startup counter and armed, and outputs sync2, rise and fall. Registers, handshake, PEND and pad drive stay in gpio_port.

Test Plan:
- Reset with WIDTH=8 and pads pulled to 0xFF, then release rst_n → after 3 cycles DATA_IN reads 0xFF, PEND reads 0x00, gpio_irq = 0, and the pads are not driven.
- Write DIR=0x0F, then DATA_OUT=0xA5 → pads show 0bzzzz_0101. A read of DATA_IN issued 2 cycles later returns 0xz5-resolved pad value (0x?5 with the upper nibble from the external pulls). Each access acks after exactly 1 cycle.
- RISE=0x01, MASK=0x01; drive pad0 from 0 to 1 before edge k → PEND bit0 set at edge k+2, gpio_irq = 1. Write PEND=0x01 → irq 0 and PEND reads 0x00.
- RISE=FALL=0x02; pulse pad1 high for 4 cycles → PEND bit1 set on the rise. After a W1C clear, the fall sets it again.
- W1C of PEND bit0 in the same cycle as a new rising event on pin0 → bit0 stays 1.
- Hold gpio_enable high with reads of regs 0..7 in sequence → gpio_ready toggles 0/1 (one access per 2 cycles). Reg 7 returns 0. A write of 0xFFFF_FFFF to MASK reads back 0x0000_00FF.
